// File: rtl/sig_pkg.sv
// rtl/sig_pkg.sv - shared types and constants for the signal loader/saver pair
package sig_pkg;

  localparam int SAMPLES_DEFAULT = 320;
  localparam int SAMPLE_W        = 16;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT,
    DRAIN,
    DONE
  } state_t;

endpackage

// File: rtl/sig_loader_if.sv
// rtl/sig_loader_if.sv - DMA read port and profile sample stream of the signal loader
interface sig_loader_if;
  import sig_pkg::*;

  logic [31:0]         dma1_addr;
  logic                dma1_read;
  logic [31:0]         dma1_readdata;
  logic                dma1_rdy;
  logic [SAMPLE_W-1:0] profile_data;
  logic                profile_valid;
  logic                profile_rdy;

  // master is the loader; slave is the memory plus the sample consumer
  modport master (
    output dma1_addr, dma1_read, profile_data, profile_valid,
    input  dma1_readdata, dma1_rdy, profile_rdy
  );

  modport slave (
    input  dma1_addr, dma1_read, profile_data, profile_valid,
    output dma1_readdata, dma1_rdy, profile_rdy
  );

endinterface

// File: rtl/sig_sample_fifo.sv
// rtl/sig_sample_fifo.sv - sample FIFO with dual-entry push and single pop
module sig_sample_fifo
  import sig_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int PW    = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                push2,
  input  logic [31:0]         din,
  input  logic                pop,
  output logic [SAMPLE_W-1:0] dout,
  output logic [CW-1:0]       count,
  output logic                empty,
  output logic [CW-1:0]       free
);

  logic [SAMPLE_W-1:0] mem [DEPTH];
  logic [PW-1:0]       wr_ptr;
  logic [PW-1:0]       rd_ptr;
  logic [CW-1:0]       inc;
  logic [CW-1:0]       dec;

  assign inc   = push2 ? CW'(2) : '0;
  assign dec   = pop ? CW'(1) : '0;
  assign empty = (count == '0);
  assign free  = CW'(DEPTH) - count;
  assign dout  = empty ? '0 : mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push2) wr_ptr <= wr_ptr + PW'(2);
      if (pop)   rd_ptr <= rd_ptr + PW'(1);
      count <= count + inc - dec;
    end
  end

  always_ff @(posedge clk) begin
    if (push2) begin
      mem[wr_ptr]          <= din[15:0];
      mem[wr_ptr + PW'(1)] <= din[31:16];
    end
  end

endmodule

// File: rtl/sig_loader.sv
// rtl/sig_loader.sv - DMA block reader that unpacks 32-bit words into a 16-bit sample stream
module sig_loader
  import sig_pkg::*;
#(
  parameter int SAMPLES    = SAMPLES_DEFAULT,
  parameter int FIFO_DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [31:0]  start_addr_read,
  sig_loader_if.master bus,
  output logic         busy,
  output logic         irq
);

  localparam int WORDS = SAMPLES / 2;
  localparam int WRW   = $clog2(WORDS + 1);
  localparam int CW    = $clog2(FIFO_DEPTH + 1);

  state_t              state;
  state_t              state_n;
  logic [31:0]         addr;
  logic [WRW-1:0]      words_req;

  logic                push2;
  logic                pop;
  logic                issue;
  logic                drain_empty;
  logic [CW-1:0]       fifo_count;
  logic [CW-1:0]       fifo_free;
  logic                fifo_empty;
  logic [SAMPLE_W-1:0] fifo_dout;

  sig_sample_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push2 (push2),
    .din   (bus.dma1_readdata),
    .pop   (pop),
    .dout  (fifo_dout),
    .count (fifo_count),
    .empty (fifo_empty),
    .free  (fifo_free)
  );

  // A read is only issued when the whole word is guaranteed a slot.
  assign issue = (state == FETCH) && (words_req < WRW'(WORDS)) && (fifo_free >= CW'(2));
  assign push2 = (state == WAIT) && bus.dma1_rdy;
  assign pop   = bus.profile_valid && bus.profile_rdy;

  // DONE must coincide with the first empty cycle, so look one pop ahead.
  assign drain_empty = fifo_empty || ((fifo_count == CW'(1)) && pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      addr      <= '0;
      words_req <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && start) begin
        addr      <= start_addr_read;
        words_req <= '0;
      end else if (issue) begin
        addr      <= addr + 32'd4;
        words_req <= words_req + WRW'(1);
      end
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = FETCH;
      FETCH:   if (issue) state_n = WAIT;
      WAIT:    if (bus.dma1_rdy) state_n = (words_req == WRW'(WORDS)) ? DRAIN : FETCH;
      DRAIN:   if (drain_empty) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign bus.dma1_read     = issue;
  assign bus.dma1_addr     = issue ? addr : 32'd0;
  assign bus.profile_data  = fifo_dout;
  assign bus.profile_valid = !fifo_empty;
  assign busy              = (state != IDLE);
  assign irq               = (state == DONE);

endmodule

// File: tb/tb_sig_loader.sv
// tb/tb_sig_loader.sv - scoreboard bench for sig_loader
module tb_sig_loader;
  import sig_pkg::*;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start;
  logic [31:0] start_addr_read;
  logic        busy;
  logic        irq;
  logic        start2;
  logic [31:0] start_addr2;
  logic        busy2;
  logic        irq2;

  sig_loader_if bus ();
  sig_loader_if bus2 ();

  sig_loader #(.SAMPLES(320), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .start(start), .start_addr_read(start_addr_read),
    .bus(bus.master), .busy(busy), .irq(irq)
  );

  sig_loader #(.SAMPLES(2), .FIFO_DEPTH(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .start_addr_read(start_addr2),
    .bus(bus2.master), .busy(busy2), .irq(irq2)
  );

  int          n_cmp = 0;
  int          n_fail = 0;
  int          cyc = 0;
  logic [31:0] exp_a[$];
  logic [15:0] exp_s[$];
  int          occ = 0;
  int          pops = 0;
  int          n_irq = 0;
  int          last_pop_cyc = 0;
  int          start_cyc = 0;
  int          gen = 0;
  int          late_req = 0;
  int          late_done = 0;
  int          irq_base = 0;
  bit          outstanding = 0;
  bit          first_pending = 0;
  bit          prev_irq = 0;
  bit          bp_mode = 0;
  bit          var_lat = 0;
  logic [31:0] cur_base = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Consumer ready: always 1, or 30% duty under backpressure.
  initial begin
    bus.profile_rdy = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.profile_rdy = bp_mode ? ($urandom_range(0, 99) < 30) : 1'b1;
    end
  end

  // Memory responder: one response per read, plus on-demand stale pulses.
  initial begin : responder
    logic [31:0] a;
    logic [31:0] off;
    int          g;
    int          lat;
    int          idx;
    bus.dma1_rdy      = 1'b0;
    bus.dma1_readdata = 32'd0;
    forever begin
      @(negedge clk);
      if (bus.dma1_read && !rst) begin
        a   = bus.dma1_addr;
        g   = gen;
        lat = var_lat ? int'($urandom_range(1, 20)) : 2;
        repeat (lat) @(posedge clk);
        #1;
        if (g == gen) begin
          off = a - cur_base;
          idx = int'(off >> 2);
          bus.dma1_readdata = {16'(2 * idx + 1), 16'(2 * idx)};
          bus.dma1_rdy      = 1'b1;
        end
        @(posedge clk);
        #1;
        bus.dma1_rdy = 1'b0;
      end else if (late_done != late_req) begin
        @(posedge clk);
        #1;
        bus.dma1_readdata = 32'hDEAD_BEEF;
        bus.dma1_rdy      = 1'b1;
        @(posedge clk);
        #1;
        bus.dma1_rdy = 1'b0;
        late_done++;
      end
    end
  end

  // Monitor: occupancy model, address and sample scoreboard, irq timing.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        occ = 0;
        outstanding = 0;
        first_pending = 0;
        prev_irq = 0;
        exp_a.delete();
        exp_s.delete();
        gen++;
      end else begin
        if (prev_irq) check("busy_after_irq", 32'(busy), 32'd0);
        check("valid_vs_model", 32'(bus.profile_valid), 32'(occ > 0));
        if (!bus.profile_valid) check("data_when_empty", 32'(bus.profile_data), 32'd0);
        if (!bus.dma1_read) check("addr_zero_no_read", bus.dma1_addr, 32'd0);
        if (bus.dma1_rdy && outstanding) begin
          occ += 2;
          outstanding = 0;
        end
        if (bus.dma1_read) begin
          check("single_outstanding", 32'(outstanding), 32'd0);
          check("read_free_slots", 32'(occ <= 2), 32'd1);
          if (first_pending) begin
            check("first_read_latency", cyc, start_cyc + 1);
            first_pending = 0;
          end
          if (exp_a.size() == 0) check("unexpected_read", bus.dma1_addr, 32'hFFFF_FFFF);
          else check("read_addr", bus.dma1_addr, exp_a.pop_front());
          outstanding = 1;
        end
        if (bus.profile_valid && bus.profile_rdy) begin
          if (exp_s.size() == 0) check("unexpected_sample", 32'(bus.profile_data), 32'hFFFF_FFFF);
          else check("sample", 32'(bus.profile_data), 32'(exp_s.pop_front()));
          occ--;
          pops++;
          last_pop_cyc = cyc;
        end
        check("occ_le_depth", 32'(occ <= 4 && occ >= 0), 32'd1);
        if (irq) begin
          n_irq++;
          check("irq_after_last_pop", cyc, last_pop_cyc + 1);
          check("busy_in_irq", 32'(busy), 32'd1);
          check("irq_all_samples", exp_s.size(), 32'd0);
        end
        prev_irq = irq;
      end
    end
  end

  task automatic start_block(input logic [31:0] base);
    cur_base = base;
    for (int i = 0; i < 160; i++) exp_a.push_back(base + 32'(4 * i));
    for (int i = 0; i < 320; i++) exp_s.push_back(16'(i));
    irq_base = n_irq;
    @(posedge clk);
    #1;
    start_addr_read = base;
    start           = 1'b1;
    start_cyc       = cyc;
    first_pending   = 1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    check("busy_after_start", 32'(busy), 32'd1);
  endtask

  task automatic wait_pops(input int n);
    int pb;
    bit ok;
    pb = pops;
    ok = 0;
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      if (pops - pb >= n) begin
        ok = 1;
        break;
      end
    end
    check("pop_timeout", 32'(ok), 32'd1);
  endtask

  task automatic wait_block(input string name);
    bit ok;
    ok = 0;
    for (int i = 0; i < 30000; i++) begin
      @(negedge clk);
      if (n_irq > irq_base) begin
        ok = 1;
        break;
      end
    end
    check({name, "_done"}, 32'(ok), 32'd1);
    repeat (6) @(negedge clk);
    check({name, "_one_irq"}, n_irq - irq_base, 32'd1);
    check({name, "_samples_left"}, exp_s.size(), 32'd0);
    check({name, "_addrs_left"}, exp_a.size(), 32'd0);
  endtask

  initial begin
    int irq_before;
    bit ok;
    rst               = 1'b1;
    start             = 1'b0;
    start_addr_read   = 32'd0;
    start2            = 1'b0;
    start_addr2       = 32'd0;
    bus2.dma1_rdy      = 1'b0;
    bus2.dma1_readdata = 32'd0;
    bus2.profile_rdy   = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_read", 32'(bus.dma1_read), 32'd0);
    check("rst_addr", bus.dma1_addr, 32'd0);
    check("rst_valid", 32'(bus.profile_valid), 32'd0);
    check("rst_data", 32'(bus.profile_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst2_busy", 32'(busy2), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Basic block, fixed latency, consumer always ready.
    start_block(32'h0000_0100);
    wait_block("basic");

    // Backpressure.
    bp_mode = 1;
    start_block(32'h0000_2000);
    wait_block("backpressure");
    bp_mode = 0;

    // Variable DMA latency.
    var_lat = 1;
    start_block(32'h0000_3000);
    wait_block("var_latency");
    var_lat = 0;

    // Second start mid-block is ignored.
    start_block(32'h0000_5000);
    wait_pops(50);
    @(posedge clk);
    #1;
    start_addr_read = 32'hDEAD_0000;
    start           = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_block("mid_start");

    // Reset mid-block, then a stale response in IDLE.
    var_lat = 1;
    start_block(32'h0000_4000);
    wait_pops(100);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    var_lat = 0;
    irq_before = n_irq;
    repeat (25) @(posedge clk);
    late_req++;
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (late_done == late_req) begin
        ok = 1;
        break;
      end
    end
    check("late_rdy_issued", 32'(ok), 32'd1);
    repeat (3) @(negedge clk);
    check("post_rst_valid", 32'(bus.profile_valid), 32'd0);
    check("post_rst_data", 32'(bus.profile_data), 32'd0);
    check("post_rst_read", 32'(bus.dma1_read), 32'd0);
    check("post_rst_busy", 32'(busy), 32'd0);
    check("post_rst_no_irq", n_irq - irq_before, 32'd0);
    start_block(32'h0000_1000);
    wait_block("after_rst");

    // SAMPLES=2 instance at the top of the address space.
    @(posedge clk);
    #1;
    start_addr2 = 32'hFFFF_FFFC;
    start2      = 1'b1;
    @(posedge clk);
    #1;
    start2 = 1'b0;
    @(negedge clk);
    check("edge_read", 32'(bus2.dma1_read), 32'd1);
    check("edge_addr", bus2.dma1_addr, 32'hFFFF_FFFC);
    check("edge_busy", 32'(busy2), 32'd1);
    @(posedge clk);
    #1;
    bus2.dma1_readdata = 32'h0001_0000;
    bus2.dma1_rdy      = 1'b1;
    @(negedge clk);
    check("edge_wait_read", 32'(bus2.dma1_read), 32'd0);
    check("edge_wait_valid", 32'(bus2.profile_valid), 32'd0);
    @(posedge clk);
    #1;
    bus2.dma1_rdy = 1'b0;
    @(negedge clk);
    check("edge_s0_valid", 32'(bus2.profile_valid), 32'd1);
    check("edge_s0", 32'(bus2.profile_data), 32'h0000);
    check("edge_s0_read", 32'(bus2.dma1_read), 32'd0);
    @(negedge clk);
    check("edge_s1_valid", 32'(bus2.profile_valid), 32'd1);
    check("edge_s1", 32'(bus2.profile_data), 32'h0001);
    check("edge_s1_irq", 32'(irq2), 32'd0);
    @(negedge clk);
    check("edge_irq", 32'(irq2), 32'd1);
    check("edge_irq_busy", 32'(busy2), 32'd1);
    check("edge_irq_valid", 32'(bus2.profile_valid), 32'd0);
    @(negedge clk);
    check("edge_idle_irq", 32'(irq2), 32'd0);
    check("edge_idle_busy", 32'(busy2), 32'd0);
    check("edge_idle_read", 32'(bus2.dma1_read), 32'd0);
    check("edge_addr_wrap", dut2.addr, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
